// File: rtl/fredkin_pkg.sv
// Shared defaults and sizing helpers for the inverse Fredkin gate block.
package fredkin_pkg;

    // Default width of each data lane (P/Q/R and A/B/C).
    localparam int DEF_WIDTH = 32;

    // Default width of the beat and error statistics counters.
    localparam int DEF_CNT_W = 16;

    // Number of bits needed to hold the ones count of three lanes of the
    // given width: the count ranges from 0 to 3*width inclusive.
    function automatic int sum_width(input int width);
        return $clog2(3 * width + 1);
    endfunction

endpackage

// File: rtl/fredkin_popcount.sv
// Counts the ones across a packed group of three data lanes.
module fredkin_popcount
    import fredkin_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    localparam int SUM_W = sum_width(WIDTH)
) (
    input  logic [3*WIDTH-1:0] bits,
    output logic [SUM_W-1:0]   sum
);

    // Plain adder chain over every bit; SUM_W is wide enough for the worst case.
    always_comb begin
        sum = '0;
        for (int i = 0; i < 3 * WIDTH; i++) begin
            sum = sum + SUM_W'(bits[i]);
        end
    end

endmodule

// File: rtl/fredkin_inverse.sv
// Inverse Fredkin (controlled swap) recovery with a two-stage elastic
// pipeline, ones-conservation checking and delivery statistics.
//
// Stage 1 holds the recovered triple together with the ones count of the
// incoming P/Q/R. Stage 2 holds the triple again together with a flag that
// says whether the recovered triple still carries the same number of ones.
// A controlled swap never changes the ones count, so any difference means
// the beat was corrupted (on purpose via err_inject, or by a real fault).
module fredkin_inverse
    import fredkin_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] P,
    input  logic [WIDTH-1:0] Q,
    input  logic [WIDTH-1:0] R,
    input  logic             err_inject,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic             cons_err,
    input  logic             clr,
    output logic [CNT_W-1:0] beat_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int SUM_W = sum_width(WIDTH);

    // Stage 1 registers.
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [WIDTH-1:0] s1_c;
    logic [SUM_W-1:0] s1_sum;

    // Stage 2 registers, which are also the output registers.
    logic             s2_valid;
    logic [WIDTH-1:0] s2_a;
    logic [WIDTH-1:0] s2_b;
    logic [WIDTH-1:0] s2_c;
    logic             s2_err;

    // Combinational recovery of the incoming beat.
    logic [WIDTH-1:0] rec_a;
    logic [WIDTH-1:0] rec_b;
    logic [WIDTH-1:0] rec_c;

    // Ones counts of the incoming triple and of the stage 1 recovered triple.
    logic [SUM_W-1:0] in_sum;
    logic [SUM_W-1:0] s1_rec_sum;

    // Pipeline advance controls and output handshake.
    logic             adv1;
    logic             adv2;
    logic             out_fire;

    // Stage 2 may move when it is empty or its beat is being taken; stage 1
    // may move when it is empty or stage 2 makes room. in_ready follows
    // stage 1, so out_ready reaches in_ready through plain logic.
    assign adv2     = !s2_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;
    assign out_fire = s2_valid && out_ready;

    // Undo the controlled swap: where P is set, Q and R were exchanged.
    // err_inject deliberately breaks bit 0 of B so the checker can be exercised.
    always_comb begin
        rec_a    = P;
        rec_b    = (P & R) | (~P & Q);
        rec_c    = (P & Q) | (~P & R);
        rec_b[0] = rec_b[0] ^ err_inject;
    end

    fredkin_popcount #(
        .WIDTH (WIDTH)
    ) u_in_popcount (
        .bits ({P, Q, R}),
        .sum  (in_sum)
    );

    fredkin_popcount #(
        .WIDTH (WIDTH)
    ) u_s1_popcount (
        .bits ({s1_a, s1_b, s1_c}),
        .sum  (s1_rec_sum)
    );

    // Stage 1: capture the recovered beat and the ones count of its source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c     <= '0;
            s1_sum   <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a   <= rec_a;
                s1_b   <= rec_b;
                s1_c   <= rec_c;
                s1_sum <= in_sum;
            end
        end
    end

    // Stage 2: forward the triple and flag a change in the ones count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_a     <= '0;
            s2_b     <= '0;
            s2_c     <= '0;
            s2_err   <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_a   <= s1_a;
                s2_b   <= s1_b;
                s2_c   <= s1_c;
                s2_err <= (s1_rec_sum != s1_sum);
            end
        end
    end

    // Delivery statistics: beat count wraps, error count sticks at all ones,
    // and a clear overrides any increment in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_count <= '0;
            err_count  <= '0;
        end else if (clr) begin
            beat_count <= '0;
            err_count  <= '0;
        end else if (out_fire) begin
            beat_count <= beat_count + 1'b1;
            if (s2_err && (err_count != {CNT_W{1'b1}})) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

    assign out_valid = s2_valid;
    assign A         = s2_a;
    assign B         = s2_b;
    assign C         = s2_c;
    assign cons_err  = s2_err;

endmodule

// File: tb/tb_fredkin_inverse.sv
// Self-checking bench for fredkin_inverse. Beats are built by passing an
// original triple through the forward Fredkin gate; the reference model
// expects that original triple back (B bit 0 flipped and cons_err set when
// the beat was corrupted), in the order the beats were accepted.
module tb_fredkin_inverse;

    localparam int WIDTH = 32;
    // Narrow counters so saturation and wrap are reachable in a few hundred beats.
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] P;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             err_inject;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic             cons_err;
    logic             clr;
    logic [CNT_W-1:0] beat_count;
    logic [CNT_W-1:0] err_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
        logic             e;
    } beat_t;

    beat_t exp_q[$];

    logic [WIDTH-1:0] cur_a;
    logic [WIDTH-1:0] cur_b;
    logic [WIDTH-1:0] cur_c;
    int               out_seen  = 0;
    int               cons_seen = 0;
    bit               rand_ready = 1'b0;

    fredkin_inverse #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .P          (P),
        .Q          (Q),
        .R          (R),
        .err_inject (err_inject),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .A          (A),
        .B          (B),
        .C          (C),
        .cons_err   (cons_err),
        .clr        (clr),
        .beat_count (beat_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    // One comparison point: counts it and reports tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive the forward-gate image of an original triple onto P/Q/R.
    task automatic setBeat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] c, input logic err);
        cur_a      = a;
        cur_b      = b;
        cur_c      = c;
        P          = a;
        Q          = (~a & b) | (a & c);
        R          = (~a & c) | (a & b);
        err_inject = err;
    endtask

    // Present one beat and hold it until accepted; returns the edges waited.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] c, input logic err,
                                 output int cycles);
        bit taken;
        taken  = 1'b0;
        cycles = 0;
        setBeat(a, b, c, err);
        in_valid = 1'b1;
        while (!taken) begin
            @(negedge clk);
            taken = in_ready;
            @(posedge clk);
            #1;
            cycles++;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            if (!taken && cycles > 50) begin
                checkOutput("accept_timeout", 64'(in_ready), 64'd1);
                taken = 1'b1;
            end
        end
        in_valid   = 1'b0;
        err_inject = 1'b0;
    endtask

    // Let every outstanding beat leave the pipeline.
    task automatic drainPipe();
        int t;
        t = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        checkOutput("drain_done", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic clearCounters();
        @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        checkOutput("clr_beat_count", 64'(beat_count), 64'd0);
        checkOutput("clr_err_count", 64'(err_count), 64'd0);
    endtask

    // Scoreboard: handshakes are judged at the falling edge, ahead of the
    // rising edge where they take effect.
    always @(negedge clk) begin
        beat_t e;
        beat_t n;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_beat", 64'(out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_a", 64'(A), 64'(e.a));
                    checkOutput("out_b", 64'(B), 64'(e.b));
                    checkOutput("out_c", 64'(C), 64'(e.c));
                    checkOutput("out_cons_err", 64'(cons_err), 64'(e.e));
                    out_seen++;
                    if (cons_err) cons_seen++;
                end
            end
            if (in_valid && in_ready) begin
                n.a = cur_a;
                n.b = cur_b ^ WIDTH'(err_inject);
                n.c = cur_c;
                n.e = err_inject;
                exp_q.push_back(n);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int seen0;
        int cons0;
        logic [WIDTH-1:0] xa, xb, xc;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        P          = '0;
        Q          = '0;
        R          = '0;
        err_inject = 1'b0;
        out_ready  = 1'b1;
        clr        = 1'b0;
        cur_a      = '0;
        cur_b      = '0;
        cur_c      = '0;

        // Reset state.
        #12;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_beat_count", 64'(beat_count), 64'd0);
        checkOutput("rst_err_count", 64'(err_count), 64'd0);
        checkOutput("rst_a", 64'(A), 64'd0);

        // Directed vector, accepted on the first edge after reset release.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(32'hFFFF0000, 32'h9ABC5678, 32'h1234DEF0, 1'b0, cyc);
        checkOutput("first_accept_edges", 64'(cyc), 64'd1);
        checkOutput("dir_not_early", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("dir_out_valid", 64'(out_valid), 64'd1);
        checkOutput("dir_a", 64'(A), 64'h0000_0000_FFFF_0000);
        checkOutput("dir_b", 64'(B), 64'h0000_0000_9ABC_5678);
        checkOutput("dir_c", 64'(C), 64'h0000_0000_1234_DEF0);
        checkOutput("dir_cons_err", 64'(cons_err), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("dir_beat_count", 64'(beat_count), 64'd1);

        // 100 random beats with random back-pressure.
        clearCounters();
        seen0 = out_seen;
        rand_ready = 1'b1;
        for (int n = 0; n < 100; n++) begin
            applyStimulus($urandom, $urandom, $urandom, 1'b0, cyc);
        end
        rand_ready = 1'b0;
        drainPipe();
        checkOutput("rand_beat_count", 64'(beat_count), 64'd100);
        checkOutput("rand_err_count", 64'(err_count), 64'd0);
        checkOutput("rand_delivered", 64'(out_seen - seen0), 64'd100);

        // Error injection on beat 3 of 5.
        clearCounters();
        cons0 = cons_seen;
        for (int n = 1; n <= 5; n++) begin
            applyStimulus($urandom, $urandom, $urandom, (n == 3), cyc);
        end
        drainPipe();
        checkOutput("inj_err_count", 64'(err_count), 64'd1);
        checkOutput("inj_beat_count", 64'(beat_count), 64'd5);
        checkOutput("inj_cons_beats", 64'(cons_seen - cons0), 64'd1);

        // Stall: two beats fill the pipe, a third waits with in_valid high.
        out_ready = 1'b0;
        xa = $urandom;
        xb = $urandom;
        xc = $urandom;
        applyStimulus(xa, xb, xc, 1'b0, cyc);
        applyStimulus($urandom, $urandom, $urandom, 1'b0, cyc);
        setBeat($urandom, $urandom, $urandom, 1'b0);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
            checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
            checkOutput("stall_a", 64'(A), 64'(xa));
            checkOutput("stall_b", 64'(B), 64'(xb));
            checkOutput("stall_c", 64'(C), 64'(xc));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drainPipe();
        checkOutput("stall_beat_count", 64'(beat_count), 64'd8);

        // Reset while both stages hold beats.
        out_ready = 1'b0;
        applyStimulus($urandom, $urandom, $urandom, 1'b0, cyc);
        applyStimulus($urandom, $urandom, $urandom, 1'b0, cyc);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("mid_rst_beat_count", 64'(beat_count), 64'd0);
        checkOutput("mid_rst_err_count", 64'(err_count), 64'd0);
        checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("mid_rst_b", 64'(B), 64'd0);
        exp_q.delete();
        #3;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checkOutput("post_rst_idle", 64'(out_valid), 64'd0);
        end

        // Saturate the error counter, then wrap the beat counter.
        clearCounters();
        for (int n = 0; n < int'(CNT_MAX); n++) begin
            applyStimulus($urandom, $urandom, $urandom, 1'b1, cyc);
        end
        drainPipe();
        checkOutput("sat_err_full", 64'(err_count), 64'(CNT_MAX));
        checkOutput("sat_beat_full", 64'(beat_count), 64'(CNT_MAX));
        applyStimulus($urandom, $urandom, $urandom, 1'b1, cyc);
        drainPipe();
        checkOutput("sat_err_held", 64'(err_count), 64'(CNT_MAX));
        checkOutput("wrap_beat_count", 64'(beat_count), 64'd0);
        applyStimulus($urandom, $urandom, $urandom, 1'b0, cyc);
        drainPipe();
        checkOutput("wrap_beat_next", 64'(beat_count), 64'd1);

        // Clear landing on the same edge as an erroneous output handshake.
        out_ready = 1'b0;
        applyStimulus($urandom, $urandom, $urandom, 1'b1, cyc);
        @(posedge clk);
        #1;
        checkOutput("clr_hs_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        clr       = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        checkOutput("clr_hs_beat_count", 64'(beat_count), 64'd0);
        checkOutput("clr_hs_err_count", 64'(err_count), 64'd0);
        drainPipe();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
